// File: rtl/key_schedule_gen.sv
// AES key expansion engine for 128/192/256-bit keys: generates one schedule word per
// cycle into a 60-word store and serves 128-bit round keys with one cycle of read latency.

module key_schedule_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the MSBs, so the byte for index x starts at bit 8*(255-x).
   logic [10:0] bit_pos;
   assign bit_pos = {3'b000, ~in_i} << 3;
   assign out_o   = SBOX_TABLE[bit_pos +: 8];
endmodule

module key_schedule_gen #(
   parameter int MAX_NK   = 8,
   parameter int RK_WIDTH = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          key_len,
   input  logic [255:0]        key_in,
   output logic                ready,
   output logic                busy,
   output logic                done,
   output logic                key_valid,
   output logic                cfg_err,
   input  logic                rd_en,
   input  logic [3:0]          rd_round,
   input  logic                rd_inv,
   output logic [RK_WIDTH-1:0] rk_o,
   output logic                rk_valid,
   output logic                rk_err
);
   typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_e;

   state_e              state_q;
   logic [31:0]         w_q [60];
   logic [5:0]          i_q;
   logic [2:0]          mod_q;
   logic [3:0]          nk_q;
   logic [3:0]          nr_q;
   logic [7:0]          rcon_q;
   logic                key_valid_q;
   logic                cfg_err_q;
   logic                rk_valid_q;
   logic                rk_err_q;
   logic [RK_WIDTH-1:0] rk_q;

   logic [3:0]          start_nk;
   logic [3:0]          start_nr;
   logic                start_bad;
   logic                start_ok;
   logic                start_rej;
   logic [31:0]         prev_word;
   logic [31:0]         back_word;
   logic [31:0]         sub_in;
   logic [31:0]         sub_out;
   logic [31:0]         temp_word;
   logic [31:0]         word_d;
   logic [7:0]          rcon_d;
   logic                mod_last;
   logic                gen_last;
   logic                rd_ok;
   logic [3:0]          rd_idx;
   logic [RK_WIDTH-1:0] rk_d;

   always_comb begin
      start_nk = 4'd4;
      start_nr = 4'd10;
      case (key_len)
         2'b01: begin
            start_nk = 4'd6;
            start_nr = 4'd12;
         end
         2'b10: begin
            start_nk = 4'd8;
            start_nr = 4'd14;
         end
         default: ;
      endcase
      start_bad = (key_len == 2'b11) || (int'(start_nk) > MAX_NK);
   end

   assign start_ok  = (state_q == S_IDLE) && start && !start_bad;
   assign start_rej = (state_q == S_IDLE) && start && start_bad;

   // Word recurrence: mod_q holds i mod Nk, so no divider is needed.
   assign prev_word = w_q[i_q - 6'd1];
   assign back_word = w_q[i_q - {2'b00, nk_q}];
   assign sub_in    = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

   for (genvar b = 0; b < 4; b++) begin : g_subword
      key_schedule_sbox u_sbox (
         .in_i  (sub_in[8*b +: 8]),
         .out_o (sub_out[8*b +: 8])
      );
   end

   always_comb begin
      temp_word = prev_word;
      if (mod_q == 3'd0)
         temp_word = sub_out ^ {rcon_q, 24'h000000};
      else if (nk_q == 4'd8 && mod_q == 3'd4)
         temp_word = sub_out;
   end

   assign word_d   = back_word ^ temp_word;
   assign rcon_d   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   assign mod_last = ({1'b0, mod_q} == nk_q - 4'd1);
   assign gen_last = (i_q == {nr_q, 2'b11});

   assign rd_ok  = key_valid_q && (rd_round <= nr_q);
   assign rd_idx = rd_inv ? nr_q - rd_round : rd_round;
   assign rk_d   = {w_q[{rd_idx, 2'b00}], w_q[{rd_idx, 2'b01}],
                    w_q[{rd_idx, 2'b10}], w_q[{rd_idx, 2'b11}]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         mod_q       <= '0;
         nk_q        <= 4'd4;
         nr_q        <= 4'd10;
         rcon_q      <= 8'h01;
         key_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         rk_valid_q  <= 1'b0;
         rk_err_q    <= 1'b0;
         rk_q        <= '0;
      end else begin
         cfg_err_q <= start_rej;
         rk_err_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  nk_q        <= start_nk;
                  nr_q        <= start_nr;
                  i_q         <= {2'b00, start_nk};
                  mod_q       <= '0;
                  rcon_q      <= 8'h01;
                  key_valid_q <= 1'b0;
                  state_q     <= S_GEN;
               end
            end
            S_GEN: begin
               i_q   <= i_q + 6'd1;
               mod_q <= mod_last ? 3'd0 : mod_q + 3'd1;
               if (mod_q == 3'd0)
                  rcon_q <= rcon_d;
               if (gen_last) begin
                  key_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // An accepted start invalidates the last round key before any read is served.
         if (start_ok) begin
            rk_valid_q <= 1'b0;
         end else if (rd_en) begin
            if (rd_ok) begin
               rk_q       <= rk_d;
               rk_valid_q <= 1'b1;
            end else begin
               rk_err_q   <= 1'b1;
               rk_valid_q <= 1'b0;
            end
         end
      end
   end

   // NOTE: the word store has no reset; key_valid alone decides whether its contents are usable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (start_ok) begin
            for (int k = 0; k < 8; k++) begin
               if (k < int'(start_nk))
                  w_q[6'(k)] <= key_in[8'(255 - 32 * k) -: 32];
            end
         end else if (state_q == S_GEN) begin
            w_q[i_q] <= word_d;
         end
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign busy      = (state_q == S_GEN);
   assign done      = (state_q == S_DONE);
   assign key_valid = key_valid_q;
   assign cfg_err   = cfg_err_q;
   assign rk_o      = rk_q;
   assign rk_valid  = rk_valid_q;
   assign rk_err    = rk_err_q;
endmodule

// File: doc/key_schedule_gen.md
KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

Interface
REQ-001 SHALL provide parameter MAX_NK, default 8, meaning the largest supported key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL provide parameter RK_WIDTH, default 128, meaning the round-key output width; fixed at one AES block.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to expand key_in; sampled only while ready=1.
REQ-006 key_len  input  2  key size: 00=128 (Nk=4, Nr=10), 01=192 (Nk=6, Nr=12), 10=256 (Nk=8, Nr=14), 11=illegal.
REQ-007 key_in  input  256  cipher key, MSB-aligned: word0 in [255:224]; unused low words ignored.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 busy  output  1  high while words are being generated.
REQ-010 done  output  1  one-cycle pulse on schedule completion.
REQ-011 key_valid  output  1  full schedule stored and readable.
REQ-012 cfg_err  output  1  one-cycle pulse when a start is rejected.
REQ-013 rd_en  input  1  round-key read request.
REQ-014 rd_round  input  4  round index 0..Nr.
REQ-015 rd_inv  input  1  when 1, return round Nr-rd_round (decryption order).
REQ-016 rk_o  output  RK_WIDTH  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs.
REQ-017 rk_valid  output  1  rk_o valid this cycle.
REQ-018 rk_err  output  1  read rejected this cycle.

Function
REQ-019 SHALL implement FSM IDLE -> GEN -> DONE -> IDLE.
REQ-020 IDLE with start=1: if key_len=11 or key's Nk>MAX_NK, stay IDLE, pulse cfg_err next cycle, and leave the stored schedule and key_valid unchanged.
REQ-021 IDLE with legal start: latch Nk/Nr, write the Nk key words into w[0..Nk-1] on that edge, clear key_valid, set i=Nk, rcon=0x01, enter GEN.
REQ-022 GEN SHALL write exactly one word w[i] per cycle, i=Nk..4*Nr+3: 40 cycles (AES-128), 46 (AES-192), 52 (AES-256).
REQ-023 Word rule per FIPS-197: temp=w[i-1]; if i mod Nk=0, temp=SubWord(RotWord(temp)) xor {rcon,24'h0}; else if Nk=8 and i mod 8=4, temp=SubWord(temp); w[i]=w[i-Nk] xor temp.
REQ-024 SubWord SHALL use four SubBytes instances in parallel; all of a word's byte substitutions complete in its own cycle.
REQ-025 rcon SHALL be computed, not tabulated: after each use, rcon=xtime(rcon), i.e. shift left 1 and xor 0x1B on carry-out; the sequence reaches 0x36 at the 10th use.
REQ-026 i mod Nk SHALL be tracked by a wrap counter 0..Nk-1, with no divider.
REQ-027 After the final word write, enter DONE: done=1 and key_valid=1 in that cycle, busy=0; return to IDLE on the next edge.
REQ-028 start during GEN or DONE SHALL be ignored, with no cfg_err.
REQ-029 Storage SHALL be a 60x32 register array; words above 4*Nr+3 are don't-care.
REQ-030 Reads SHALL have 1-cycle latency: rd_en at edge T gives rk_o and rk_valid=1 after T, held until the next accepted read.
REQ-031 A read with key_valid=0, or rd_round>Nr, SHALL give rk_err=1 and rk_valid=0 for one cycle, with rk_o unchanged.
REQ-032 A read in the same cycle as done is legal and returns the new schedule.
REQ-033 rk_valid SHALL drop to 0 in the cycle after any accepted start.

Reset
REQ-034 With rst=1 at a clock edge, the next state SHALL be IDLE with ready=1, busy=0, done=0, key_valid=0, cfg_err=0, rk_valid=0, rk_err=0, rk_o=0, i=0, rcon=0x01.
REQ-035 Reset during GEN SHALL abandon the expansion; the stored words need not be cleared, but key_valid stays 0 until the next complete expansion.
REQ-036 Reset has priority over start and rd_en in the same cycle.

Verification
REQ-037 AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> done exactly 41 cycles after start accepted; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; rd_inv=1 with rd_round=0 returns the same value.
REQ-038 AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> round 12 = e98ba06f448c773c8ecc720401002202.
REQ-039 AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> round 14 = fe4890d1e6188d0b046df344706c631e; round 0 = first 128 key bits.
REQ-040 key_len=11, and key_len=10 with MAX_NK=4 -> cfg_err pulse, ready stays 1, previous schedule still readable.
REQ-041 Read at rd_round=11 in AES-128, or any read during GEN -> rk_err=1, rk_valid=0; start pulsed during GEN -> ignored, expansion result unchanged.
REQ-042 rst asserted at GEN cycle 20, then a new AES-256 start -> clean expansion with correct round 14, and key_valid=0 throughout.
